// File: rtl/perf_pkg.sv
// Shared types and default sizes for the performance-counter dump block.
package perf_pkg;

   localparam int unsigned PERF_CNT_WIDTH = 32;
   localparam int unsigned PERF_EVENT_NUM = 16;
   localparam int unsigned PERF_ID_WIDTH  = $clog2(PERF_EVENT_NUM);

   typedef enum logic [1:0] {
      PD_IDLE  = 2'd0,
      PD_SNAP  = 2'd1,
      PD_DRAIN = 2'd2
   } dump_state_t;

   // Beat payload at the default sizes
   typedef struct packed {
      logic [PERF_ID_WIDTH-1:0]  id;
      logic [PERF_CNT_WIDTH-1:0] cnt;
      logic                      ovf;
      logic                      last;
   } perf_beat_t;

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter with sticky wrap flag and a shadow copy taken on snap.
module perf_counter_cell
   import perf_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = PERF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inc,
   input  logic                 clear,
   input  logic                 snap,
   input  logic                 clr_on_snap,
   output logic [CNT_WIDTH-1:0] shadow_o,
   output logic                 sovf_o
);

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] shadow_q, shadow_d;
   logic                 ovf_q, ovf_d;
   logic                 sovf_q, sovf_d;

   // Shadow always takes the pre-update value; clear beats clear-on-snap beats increment
   always_comb begin
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      shadow_d = shadow_q;
      sovf_d   = sovf_q;
      if (snap) begin
         shadow_d = cnt_q;
         sovf_d   = ovf_q;
      end
      if (clear) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (snap && clr_on_snap) begin
         cnt_d = CNT_WIDTH'(inc);
         ovf_d = 1'b0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
         if (cnt_q == '1) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         shadow_q <= '0;
         sovf_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         shadow_q <= shadow_d;
         sovf_q   <= sovf_d;
      end
   end

   assign shadow_o = shadow_q;
   assign sovf_o   = sovf_q;

endmodule

// File: rtl/perf_counter_dump.sv
// Event counter bank with snapshot-and-drain readout over a valid/ready beat stream.
module perf_counter_dump
   import perf_pkg::*;
#(
   parameter int unsigned  EVENT_NUM     = PERF_EVENT_NUM,
   parameter int unsigned  CNT_WIDTH     = PERF_CNT_WIDTH,
   parameter bit           CLEAR_ON_DUMP = 1'b0,
   localparam int unsigned ID_WIDTH      = $clog2(EVENT_NUM)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_i,
   input  logic [EVENT_NUM-1:0] event_i,
   input  logic                 clear_i,
   input  logic                 dump_req_i,
   output logic                 dump_busy_o,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [ID_WIDTH-1:0]  out_id_o,
   output logic [CNT_WIDTH-1:0] out_cnt_o,
   output logic                 out_ovf_o,
   output logic                 out_last_o
);

   localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(EVENT_NUM - 1);

   typedef struct packed {
      logic [ID_WIDTH-1:0]  id;
      logic [CNT_WIDTH-1:0] cnt;
      logic                 ovf;
      logic                 last;
   } beat_t;

   dump_state_t          state_q, state_d;
   logic [ID_WIDTH-1:0]  idx_q, idx_d;
   logic                 busy_q, busy_d;
   logic                 valid_q, valid_d;
   logic                 snap_c;
   logic                 hs_c;
   beat_t                beat_c;
   logic [CNT_WIDTH-1:0] shadow [EVENT_NUM];
   logic [EVENT_NUM-1:0] sovf;

   assign snap_c = (state_q == PD_SNAP);
   assign hs_c   = valid_q && out_ready_i;

   for (genvar i = 0; i < int'(EVENT_NUM); i++) begin : g_cell
      perf_counter_cell #(
         .CNT_WIDTH(CNT_WIDTH)
      ) u_cell (
         .clk        (clk),
         .rst        (rst),
         .inc        (en_i & event_i[i]),
         .clear      (clear_i),
         .snap       (snap_c),
         .clr_on_snap(CLEAR_ON_DUMP),
         .shadow_o   (shadow[i]),
         .sovf_o     (sovf[i])
      );
   end

   // Dump sequencing; requests outside IDLE are dropped
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         PD_IDLE: begin
            if (dump_req_i) begin
               state_d = PD_SNAP;
            end
         end
         PD_SNAP: begin
            state_d = PD_DRAIN;
            idx_d   = '0;
         end
         PD_DRAIN: begin
            if (hs_c) begin
               if (idx_q == LAST_ID) begin
                  state_d = PD_IDLE;
               end else begin
                  idx_d = idx_q + ID_WIDTH'(1);
               end
            end
         end
         default: begin
            state_d = PD_IDLE;
         end
      endcase
      busy_d  = (state_d != PD_IDLE);
      valid_d = (state_d == PD_DRAIN);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= PD_IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   // Payload is zero whenever no beat is offered
   always_comb begin
      beat_c = '0;
      if (valid_q) begin
         beat_c.id   = idx_q;
         beat_c.cnt  = shadow[idx_q];
         beat_c.ovf  = sovf[idx_q];
         beat_c.last = (idx_q == LAST_ID);
      end
   end

   assign dump_busy_o = busy_q;
   assign out_valid_o = valid_q;
   assign out_id_o    = beat_c.id;
   assign out_cnt_o   = beat_c.cnt;
   assign out_ovf_o   = beat_c.ovf;
   assign out_last_o  = beat_c.last;

endmodule

// File: tb/tb_perf_counter_dump.sv
// Bench for perf_counter_dump: two configurations driven in lockstep against a queue-based model.
module tb_perf_counter_dump;

   logic        clk = 1'b0;
   logic        rst, en, clr, req, ready;
   logic [15:0] ev;

   logic        a_busy, a_valid, a_ovf, a_last;
   logic [3:0]  a_id;
   logic [31:0] a_cnt;
   logic        b_busy, b_valid, b_ovf, b_last;
   logic [3:0]  b_id;
   logic [3:0]  b_cnt;

   int checks = 0;
   int errors = 0;
   int ready_mode = 0;

   int got_cnt     [2][16];
   int got_ovf     [2][16];
   int got_seq     [2][32];
   int got_n       [2];
   int got_last_n  [2];
   int got_last_id [2];

   always #5 clk = ~clk;

   perf_counter_dump #(.EVENT_NUM(16), .CNT_WIDTH(32), .CLEAR_ON_DUMP(1'b0)) u_dut_a (
      .clk(clk), .rst(rst), .en_i(en), .event_i(ev), .clear_i(clr), .dump_req_i(req),
      .dump_busy_o(a_busy), .out_valid_o(a_valid), .out_ready_i(ready), .out_id_o(a_id),
      .out_cnt_o(a_cnt), .out_ovf_o(a_ovf), .out_last_o(a_last));

   perf_counter_dump #(.EVENT_NUM(16), .CNT_WIDTH(4), .CLEAR_ON_DUMP(1'b1)) u_dut_b (
      .clk(clk), .rst(rst), .en_i(en), .event_i(ev), .clear_i(clr), .dump_req_i(req),
      .dump_busy_o(b_busy), .out_valid_o(b_valid), .out_ready_i(ready), .out_id_o(b_id),
      .out_cnt_o(b_cnt), .out_ovf_o(b_ovf), .out_last_o(b_last));

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   // Sink readiness pattern: 0 always ready, 1 toggling, 2 random
   initial begin
      ready = 1'b1;
      forever begin
         @(negedge clk);
         case (ready_mode)
            1:       ready = ~ready;
            2:       ready = ($urandom % 3) != 0;
            default: ready = 1'b1;
         endcase
      end
   end

   // Reference model (counts as integers, dump as a queue of pending ids) and per-cycle compare
   initial begin : b_chk
      longint      mcnt  [2][16];
      bit          movf  [2][16];
      longint      scnt  [2][16];
      bit          msovf [2][16];
      int          width_c [2];
      bit          cod_c   [2];
      int          idq[$];
      bit          msnap, idle, inc;
      longint      mask;
      logic        r, e, cl, rq, rd;
      logic [15:0] ev_s;
      logic        pv [2];
      int          pid [2];
      longint      pcnt [2];
      int          povf [2];
      int          plast [2];
      logic [39:0] expv, actv;
      int          eid;

      width_c[0] = 32; width_c[1] = 4;
      cod_c[0]   = 1'b0; cod_c[1] = 1'b1;
      msnap = 1'b0;
      forever begin
         @(posedge clk);
         r = rst; e = en; cl = clr; rq = req; rd = ready; ev_s = ev;
         pv[0] = a_valid; pid[0] = int'(a_id); pcnt[0] = longint'(a_cnt);
         povf[0] = int'(a_ovf); plast[0] = int'(a_last);
         pv[1] = b_valid; pid[1] = int'(b_id); pcnt[1] = longint'(b_cnt);
         povf[1] = int'(b_ovf); plast[1] = int'(b_last);
         #1;
         for (int c = 0; c < 2; c++) begin
            if (r && pv[c] && rd && got_n[c] < 32) begin
               got_cnt[c][pid[c]] = int'(pcnt[c]);
               got_ovf[c][pid[c]] = povf[c];
               got_seq[c][got_n[c]] = pid[c];
               got_n[c]++;
               if (plast[c] != 0) begin
                  got_last_n[c]++;
                  got_last_id[c] = pid[c];
               end
            end
         end
         if (!r) begin
            for (int c = 0; c < 2; c++)
               for (int i = 0; i < 16; i++) begin
                  mcnt[c][i] = 0; movf[c][i] = 0; scnt[c][i] = 0; msovf[c][i] = 0;
               end
            idq.delete();
            msnap = 1'b0;
         end else begin
            idle = !msnap && (idq.size() == 0);
            if (idq.size() != 0 && rd) void'(idq.pop_front());
            for (int c = 0; c < 2; c++) begin
               mask = (longint'(1) << width_c[c]) - 1;
               for (int i = 0; i < 16; i++) begin
                  inc = e && ev_s[i];
                  if (msnap) begin
                     scnt[c][i]  = mcnt[c][i];
                     msovf[c][i] = movf[c][i];
                  end
                  if (cl) begin
                     mcnt[c][i] = 0; movf[c][i] = 0;
                  end else if (msnap && cod_c[c]) begin
                     mcnt[c][i] = inc ? 1 : 0; movf[c][i] = 0;
                  end else if (inc) begin
                     if (mcnt[c][i] == mask) begin
                        mcnt[c][i] = 0; movf[c][i] = 1;
                     end else begin
                        mcnt[c][i] = mcnt[c][i] + 1;
                     end
                  end
               end
            end
            if (msnap) for (int i = 0; i < 16; i++) idq.push_back(i);
            msnap = idle && rq;
         end
         for (int c = 0; c < 2; c++) begin
            expv = '0;
            expv[39] = msnap || (idq.size() != 0);
            if (idq.size() != 0) begin
               eid = idq[0];
               expv[38]    = 1'b1;
               expv[37:34] = 4'(eid);
               expv[33:2]  = 32'(scnt[c][eid]);
               expv[1]     = msovf[c][eid];
               expv[0]     = (eid == 15);
            end
            if (c == 0) actv = {a_busy, a_valid, a_valid ? {a_id, a_cnt, a_ovf, a_last} : 38'd0};
            else        actv = {b_busy, b_valid, b_valid ? {b_id, 28'd0, b_cnt, b_ovf, b_last} : 38'd0};
            checks++;
            if (actv !== expv) begin
               errors++;
               $display("FAIL cycle_dut%0d t=%0t: got busy=%0d valid=%0d id=%0d cnt=%0d ovf=%0d last=%0d, expected busy=%0d valid=%0d id=%0d cnt=%0d ovf=%0d last=%0d",
                        c, $time, actv[39], actv[38], actv[37:34], actv[33:2], actv[1], actv[0],
                        expv[39], expv[38], expv[37:34], expv[33:2], expv[1], expv[0]);
            end
         end
      end
   end

   task automatic clr_got();
      for (int c = 0; c < 2; c++) begin
         got_n[c] = 0; got_last_n[c] = 0; got_last_id[c] = -1;
         for (int i = 0; i < 16; i++) begin
            got_cnt[c][i] = -1; got_ovf[c][i] = -1;
         end
      end
   endtask

   task automatic wait_idle(input string nm);
      int k = 0;
      while (a_busy && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_idle_timeout"}, longint'(a_busy), 0);
   endtask

   task automatic check_common(input string nm);
      int bad;
      for (int c = 0; c < 2; c++) begin
         bad = 0;
         for (int k = 0; k < got_n[c]; k++) if (got_seq[c][k] != k) bad++;
         chk($sformatf("%s_beats%0d", nm, c), got_n[c], 16);
         chk($sformatf("%s_order%0d", nm, c), bad, 0);
         chk($sformatf("%s_lastn%0d", nm, c), got_last_n[c], 1);
         chk($sformatf("%s_lastid%0d", nm, c), got_last_id[c], 15);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      int s;
      for (int c = 0; c < 2; c++) begin
         s = 0;
         for (int i = 0; i < 16; i++) s += got_cnt[c][i] + got_ovf[c][i];
         chk($sformatf("%s_zero%0d", nm, c), s, 0);
      end
   endtask

   // Called at a negedge with the block idle
   task automatic do_dump(input string nm);
      clr_got();
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      chk({nm, "_lat_busy"}, longint'(a_busy), 1);
      chk({nm, "_lat_novalid"}, longint'(a_valid), 0);
      @(negedge clk);
      chk({nm, "_lat_valid"}, longint'(a_valid), 1);
      chk({nm, "_lat_id0"}, longint'(a_id), 0);
      chk({nm, "_lat_valid_b"}, longint'(b_valid), 1);
      wait_idle(nm);
      check_common(nm);
   endtask

   task automatic pulse(input int idx, input int n);
      en = 1'b1;
      ev = 16'(1) << idx;
      repeat (n) @(negedge clk);
      ev = '0;
   endtask

   task automatic clear_pulse();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; en = 1'b1; ev = 16'hFFFF; clr = 1'b0; req = 1'b0;
      clr_got();
      repeat (2) @(negedge clk);
      chk("rst_out_a", longint'({a_busy, a_valid, a_id, a_cnt, a_ovf, a_last}), 0);
      chk("rst_out_b", longint'({b_busy, b_valid, b_id, b_cnt, b_ovf, b_last}), 0);
      rst = 1'b1; ev = '0;
      @(negedge clk);
      do_dump("t1");
      chk_all_zero("t1");

      pulse(3, 5);
      pulse(0, 2);
      do_dump("t2");
      for (int c = 0; c < 2; c++) begin
         int s = 0;
         for (int i = 1; i < 16; i++) if (i != 3) s += got_cnt[c][i] + got_ovf[c][i];
         chk($sformatf("t2_id3_%0d", c), got_cnt[c][3], 5);
         chk($sformatf("t2_id0_%0d", c), got_cnt[c][0], 2);
         chk($sformatf("t2_rest_%0d", c), s, 0);
      end

      ready_mode = 1;
      pulse(7, 3);
      do_dump("t3");
      chk("t3_a_id7", got_cnt[0][7], 3);
      chk("t3_a_id3_kept", got_cnt[0][3], 5);
      chk("t3_b_id7", got_cnt[1][7], 3);
      chk("t3_b_id3_cleared", got_cnt[1][3], 0);
      ready_mode = 0;

      clear_pulse();
      clr_got();
      en = 1'b1; ev = 16'h0002;
      for (int k = 0; k < 9; k++) begin
         req = (k == 5);
         @(negedge clk);
      end
      req = 1'b0; ev = '0;
      wait_idle("t4a");
      check_common("t4a");
      chk("t4a_a_id1", got_cnt[0][1], 6);
      chk("t4a_b_id1", got_cnt[1][1], 6);
      do_dump("t4b");
      chk("t4b_a_id1", got_cnt[0][1], 9);
      chk("t4b_b_id1", got_cnt[1][1], 3);

      clear_pulse();
      pulse(2, 17);
      do_dump("t5a");
      chk("t5a_a_cnt", got_cnt[0][2], 17);
      chk("t5a_a_ovf", got_ovf[0][2], 0);
      chk("t5a_b_cnt", got_cnt[1][2], 1);
      chk("t5a_b_ovf", got_ovf[1][2], 1);
      clear_pulse();
      do_dump("t5b");
      chk_all_zero("t5b");

      pulse(5, 3);
      clr_got();
      req = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         req = (k >= 3 && k <= 8);
         clr = (k == 6);
         @(negedge clk);
      end
      req = 1'b0; clr = 1'b0;
      wait_idle("t6a");
      check_common("t6a");
      chk("t6a_a_id5", got_cnt[0][5], 3);
      chk("t6a_b_id5", got_cnt[1][5], 3);
      repeat (3) @(negedge clk);
      chk("t6a_not_queued", longint'(a_busy), 0);

      pulse(9, 2);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("t6b_valid_a", longint'(a_valid), 0);
      chk("t6b_busy_a", longint'(a_busy), 0);
      chk("t6b_valid_b", longint'(b_valid), 0);
      chk("t6b_busy_b", longint'(b_busy), 0);
      do_dump("t6c");
      chk_all_zero("t6c");

      ready_mode = 2;
      for (int k = 0; k < 3000; k++) begin
         en  = ($urandom % 8) != 0;
         ev  = 16'($urandom & $urandom);
         clr = ($urandom % 64) == 0;
         req = ($urandom % 16) == 0;
         rst = ($urandom % 500) != 0;
         @(negedge clk);
      end
      rst = 1'b1; en = 1'b0; ev = '0; clr = 1'b0; req = 1'b0; ready_mode = 0;
      wait_idle("rand_end");
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
